// File: rtl/clk_mon_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : clk_mon_pkg                                             |
// | Description : Shared types and default sizing for the clock period    |
// |               monitor (FSM state encoding, counter width, lock depth).|
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package clk_mon_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int LOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } mon_state_t;

endpackage
`default_nettype wire

// File: rtl/clk_mon_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : clk_mon_edge                                            |
// | Description : Single-register edge detector for the monitored signal. |
// |               rise/fall are combinational against the delayed copy.   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module clk_mon_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic r_sig_q;

  // One-cycle delayed copy of the monitored signal
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= sig_in;
    end
  end

  assign rise = sig_in & ~r_sig_q;
  assign fall = ~sig_in & r_sig_q;

endmodule
`default_nettype wire

// File: rtl/clk_period_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : clk_period_monitor                                      |
// | Description : Measures high/low lengths of a periodic signal in clk   |
// |               cycles, flags out-of-tolerance halves, declares lock    |
// |               after LOCK_CNT good periods and raises a sticky timeout.|
// |               Optional min/max period statistics when the macro       |
// |               CLK_MON_STATS_EN is defined (tied to 0 otherwise).      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_half,
  input  logic [7:0]       tol,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             err,
  output logic             locked,
  output logic             ovf,
  output logic [CNT_W:0]   min_period,
  output logic [CNT_W:0]   max_period
);

  localparam int              c_GR_W     = $clog2(LOCK_CNT + 1);
  localparam int              c_DEV_W    = CNT_W + 8;
  localparam logic [c_GR_W-1:0] c_LOCK_VAL = c_GR_W'(LOCK_CNT);

  mon_state_t         r_state;
  mon_state_t         w_state_nxt;
  logic               w_rise;
  logic               w_fall;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_high_cap;
  logic [CNT_W-1:0]   r_high_cnt;
  logic [CNT_W-1:0]   r_low_cnt;
  logic [CNT_W:0]     r_period_cnt;
  logic               r_err;
  logic               r_meas_valid;
  logic               r_ovf;
  logic               r_en_q;
  logic [c_GR_W-1:0]  r_good_run;

  logic               w_cnt_sat;
  logic               w_cnt_load1;
  logic               w_cnt_inc;
  logic               w_cap_high;
  logic               w_load_meas;
  logic               w_timeout;
  logic               w_clear;
  logic               w_en_rise;
  logic [CNT_W-1:0]   w_high_dev;
  logic [CNT_W-1:0]   w_low_dev;
  logic               w_err;
  logic [CNT_W:0]     w_period_new;

  clk_mon_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  assign w_cnt_sat = &r_cnt;
  assign w_en_rise = enable & ~r_en_q;

  // Unsigned absolute deviation of each half from the expected length;
  // widened before comparing with tol so nothing wraps
  assign w_high_dev   = (r_high_cap >= exp_half) ? (r_high_cap - exp_half) : (exp_half - r_high_cap);
  assign w_low_dev    = (r_cnt >= exp_half) ? (r_cnt - exp_half) : (exp_half - r_cnt);
  assign w_err        = (c_DEV_W'(w_high_dev) > c_DEV_W'(tol)) || (c_DEV_W'(w_low_dev) > c_DEV_W'(tol));
  assign w_period_new = {1'b0, r_high_cap} + {1'b0, r_cnt};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes; saturation wins over a
  // coincident edge so the edge is treated as a timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load1 = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap_high  = 1'b0;
    w_load_meas = 1'b0;
    w_timeout   = 1'b0;
    w_clear     = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (w_rise) begin
            w_state_nxt = MEAS_HIGH;
            w_cnt_load1 = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (w_cnt_sat) begin
            w_timeout   = 1'b1;
            w_state_nxt = WAIT_EDGE;
          end else if (w_fall) begin
            w_cap_high  = 1'b1;
            w_cnt_load1 = 1'b1;
            w_state_nxt = MEAS_LOW;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (w_cnt_sat) begin
            w_timeout   = 1'b1;
            w_state_nxt = WAIT_EDGE;
          end else if (w_rise) begin
            w_load_meas = 1'b1;
            w_cnt_load1 = 1'b1;
            w_state_nxt = MEAS_HIGH;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Phase length counter; starts at 1 on the cycle after an edge
  always_ff @(posedge clk) begin
    if (rst || w_clear || w_timeout) begin
      r_cnt <= '0;
    end else if (w_cnt_load1) begin
      r_cnt <= CNT_W'(1);
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Hold the high length until the closing rise completes the period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_high_cap <= '0;
    end else if (w_cap_high) begin
      r_high_cap <= r_cnt;
    end
  end

  // Result registers and the one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_period_cnt <= '0;
      r_err        <= 1'b0;
      r_meas_valid <= 1'b0;
    end else begin
      r_meas_valid <= w_load_meas;
      if (w_load_meas) begin
        r_high_cnt   <= r_high_cap;
        r_low_cnt    <= r_cnt;
        r_period_cnt <= w_period_new;
        r_err        <= w_err;
      end
    end
  end

  // Consecutive good-measurement run, saturating at the lock depth
  always_ff @(posedge clk) begin
    if (rst || w_clear || w_timeout) begin
      r_good_run <= '0;
    end else if (w_load_meas) begin
      if (w_err) begin
        r_good_run <= '0;
      end else if (r_good_run != c_LOCK_VAL) begin
        r_good_run <= r_good_run + c_GR_W'(1);
      end
    end
  end

  // Sticky timeout flag, cleared only when a new run is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_en_q <= 1'b0;
    end else begin
      r_en_q <= enable;
      if (w_en_rise) begin
        r_ovf <= 1'b0;
      end else if (w_timeout) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef CLK_MON_STATS_EN
  logic [CNT_W:0] r_min_period;
  logic [CNT_W:0] r_max_period;

  // Period extremes over all measurements since enable last rose
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min_period <= '0;
      r_max_period <= '0;
    end else if (w_en_rise) begin
      r_min_period <= '1;
      r_max_period <= '0;
    end else if (w_load_meas) begin
      if (w_period_new < r_min_period) begin
        r_min_period <= w_period_new;
      end
      if (w_period_new > r_max_period) begin
        r_max_period <= w_period_new;
      end
    end
  end

  assign min_period = r_min_period;
  assign max_period = r_max_period;
`else
  assign min_period = '0;
  assign max_period = '0;
`endif

  assign meas_valid = r_meas_valid;
  assign high_cnt   = r_high_cnt;
  assign low_cnt    = r_low_cnt;
  assign period_cnt = r_period_cnt;
  assign err        = r_err;
  assign locked     = (r_good_run == c_LOCK_VAL);
  assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_clk_period_monitor                                   |
// | Description : Self-checking bench for clk_period_monitor (CNT_W=8).   |
// |               Reference model works on run lengths of the driven      |
// |               waveform. Stats expectations follow CLK_MON_STATS_EN.   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_clk_period_monitor;

  localparam int W    = 8;
  localparam int LOCK = 4;
  localparam int SAT  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         sig_in;
  logic [W-1:0] exp_half;
  logic [7:0]   tol;
  logic         meas_valid;
  logic [W-1:0] high_cnt;
  logic [W-1:0] low_cnt;
  logic [W:0]   period_cnt;
  logic         err;
  logic         locked;
  logic         ovf;
  logic [W:0]   min_period;
  logic [W:0]   max_period;

  always #5 clk = ~clk;

  clk_period_monitor #(.CNT_W(W), .LOCK_CNT(LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sig_in     (sig_in),
    .exp_half   (exp_half),
    .tol        (tol),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period_cnt (period_cnt),
    .err        (err),
    .locked     (locked),
    .ovf        (ovf),
    .min_period (min_period),
    .max_period (max_period)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: run-length view of the waveform plus result state
  int m_en_prev, m_p, m_armed, m_meas, m_in_low, m_len, m_last_high;
  int m_good, m_ovf, m_hi, m_lo, m_err, m_min, m_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic record(input int h, input int l);
    int per;
    per   = h + l;
    m_hi  = h;
    m_lo  = l;
    m_err = (absdiff(h, int'(exp_half)) > int'(tol) || absdiff(l, int'(exp_half)) > int'(tol)) ? 1 : 0;
    if (m_err != 0) m_good = 0;
    else if (m_good < LOCK) m_good++;
`ifdef CLK_MON_STATS_EN
    if (per < m_min) m_min = per;
    if (per > m_max) m_max = per;
`endif
  endtask

  task automatic model_zero();
    m_en_prev = 0; m_p = 0; m_armed = 0; m_meas = 0; m_in_low = 0;
    m_len = 0; m_last_high = 0; m_good = 0; m_ovf = 0;
    m_hi = 0; m_lo = 0; m_err = 0; m_min = 0; m_max = 0;
  endtask

  task automatic check_outputs(input int mv);
    chk("meas_valid", meas_valid, mv);
    if (mv != 0) chk("err", err, m_err);
    chk("high_cnt", high_cnt, m_hi);
    chk("low_cnt", low_cnt, m_lo);
    chk("period_cnt", period_cnt, m_hi + m_lo);
    chk("locked", locked, (m_good == LOCK) ? 1 : 0);
    chk("ovf", ovf, m_ovf);
    chk("min_period", min_period, m_min);
    chk("max_period", max_period, m_max);
  endtask

  // One clock of stimulus: apply inputs, advance the model, check at negedge
  task automatic step(input logic s, input logic en);
    int mv;
    mv     = 0;
    sig_in = s;
    enable = en;
    if (en && m_en_prev == 0) begin
      m_ovf = 0;
`ifdef CLK_MON_STATS_EN
      m_min = (1 << (W + 1)) - 1;
      m_max = 0;
`endif
    end
    if (!en) begin
      m_armed = 0; m_meas = 0; m_good = 0;
    end else if (m_armed == 0) begin
      m_armed = 1;
    end else if (m_meas != 0 && m_len == SAT) begin
      m_ovf = 1; m_good = 0; m_meas = 0;
    end else if (s && m_p == 0) begin
      if (m_meas != 0 && m_in_low != 0) begin
        record(m_last_high, m_len);
        mv = 1;
      end
      m_meas = 1; m_in_low = 0; m_len = 1;
    end else if (!s && m_p != 0) begin
      if (m_meas != 0) begin
        m_last_high = m_len; m_in_low = 1; m_len = 1;
      end
    end else if (m_meas != 0) begin
      m_len++;
    end
    m_p       = s ? 1 : 0;
    m_en_prev = en ? 1 : 0;
    @(negedge clk);
    check_outputs(mv);
  endtask

  task automatic halves(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < h; j++) step(1'b1, 1'b1);
      for (int j = 0; j < l; j++) step(1'b0, 1'b1);
    end
  endtask

  task automatic do_reset(input logic s, input logic en);
    rst    = 1'b1;
    sig_in = s;
    enable = en;
    @(negedge clk);
    model_zero();
    check_outputs(0);
    chk("rst_err", err, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; sig_in = 1'b0; exp_half = 8'd2; tol = 8'd0;
    model_zero();
    do_reset(1'b0, 1'b0);

    // Nominal 2/2 toggling, exact match
    repeat (3) step(1'b0, 1'b1);
    halves(2, 2, 6);
    step(1'b1, 1'b1);
    chk("nom_high", high_cnt, 2);
    chk("nom_low", low_cnt, 2);
    chk("nom_period", period_cnt, 4);
    chk("nom_err", err, 0);
    chk("nom_locked", locked, 1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Toggling every cycle: out of tolerance at tol=0, in at tol=1
    repeat (3) step(1'b0, 1'b1);
    halves(1, 1, 8);
    step(1'b1, 1'b1);
    chk("fast_high", high_cnt, 1);
    chk("fast_low", low_cnt, 1);
    chk("fast_err", err, 1);
    chk("fast_locked", locked, 0);
    step(1'b0, 1'b1);
    tol = 8'd1;
    halves(1, 1, 6);
    step(1'b1, 1'b1);
    chk("fast_tol1_err", err, 0);
    step(1'b0, 1'b1);

    // Randomized half lengths and tolerance settings
    for (int k = 0; k < 4; k++) begin
      exp_half = 8'($urandom_range(8, 1));
      tol      = 8'($urandom_range(3, 0));
      for (int i = 0; i < 10; i++) begin
        halves(int'($urandom_range(12, 1)), int'($urandom_range(12, 1)), 1);
      end
    end

    // Drop enable during a high phase after lock
    exp_half = 8'd2; tol = 8'd0;
    halves(2, 2, 5);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("drop_locked", locked, 0);
    chk("drop_high", high_cnt, 2);
    chk("drop_low", low_cnt, 2);
    step(1'b0, 1'b0);

    // Signal stuck high: timeout
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (260) step(1'b1, 1'b1);
    chk("to_ovf", ovf, 1);
    chk("to_locked", locked, 0);
    halves(2, 2, 3);
    chk("to_sticky", ovf, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("to_clear", ovf, 0);

    // Reset in the middle of a low phase
    step(1'b0, 1'b1);
    halves(2, 2, 3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    do_reset(1'b0, 1'b1);
    chk("rst_high", high_cnt, 0);
    chk("rst_locked", locked, 0);
    step(1'b0, 1'b1);
    halves(2, 2, 4);
    step(1'b1, 1'b1);

    // Statistics: 2/2 then 3/3
    step(1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b1);
    halves(2, 2, 2);
    halves(3, 3, 2);
    step(1'b1, 1'b1);
`ifdef CLK_MON_STATS_EN
    chk("stats_min", min_period, 4);
    chk("stats_max", max_period, 6);
`else
    chk("stats_min_off", min_period, 0);
    chk("stats_max_off", max_period, 0);
`endif
    step(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_period_monitor.md
CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of all cycle counters and count outputs.
REQ-002 Parameter LOCK_CNT, default 4, SHALL set the number of consecutive in-tolerance measurements required for lock.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  monitor run request.
REQ-006 sig_in  input  1  monitored periodic signal, synchronous to clk.
REQ-007 exp_half  input  CNT_W  expected half-period in clk cycles.
REQ-008 tol  input  8  allowed absolute deviation per half, in cycles.
REQ-009 meas_valid  output  1  one-cycle pulse when new results load.
REQ-010 high_cnt, low_cnt  output  CNT_W each  last measured high and low lengths.
REQ-011 period_cnt  output  CNT_W+1  high_cnt+low_cnt, no truncation.
REQ-012 err  output  1  last measurement out of tolerance; valid when meas_valid=1.
REQ-013 locked  output  1  LOCK_CNT consecutive good measurements seen.
REQ-014 ovf  output  1  sticky timeout flag.
REQ-015 min_period, max_period  output  CNT_W+1 each  statistics (see Configuration).

Function
REQ-016 sig_in SHALL be registered once (sig_q); rise = sig_in & ~sig_q, fall = ~sig_in & sig_q.
REQ-017 FSM states SHALL be IDLE, WAIT_EDGE, MEAS_HIGH, MEAS_LOW.
REQ-018 IDLE -> WAIT_EDGE when enable=1; WAIT_EDGE -> MEAS_HIGH on rise, cnt loaded to 1.
REQ-019 MEAS_HIGH: cnt increments each cycle; on fall, the high length is captured (=cnt), cnt loaded to 1, next state MEAS_LOW.
REQ-020 MEAS_LOW: on rise, high_cnt, low_cnt, period_cnt and err load; cnt loaded to 1; next state MEAS_HIGH; meas_valid=1 for exactly the following cycle.
REQ-021 Counting SHALL be exact: a high phase of H clk cycles yields high_cnt=H, including H=1.
REQ-022 err SHALL be 1 iff |high-exp_half|>tol or |low-exp_half|>tol, with the comparison done unsigned and without wrap.
REQ-023 good_run SHALL increment on each good measurement, saturating at LOCK_CNT, and clear to 0 on err; locked = (good_run==LOCK_CNT).
REQ-024 When cnt reaches all-ones in MEAS_HIGH or MEAS_LOW, the block SHALL set ovf, clear good_run and locked, and go to WAIT_EDGE; no meas_valid.
REQ-025 ovf SHALL clear only on rst or on an enable 0->1 transition.
REQ-026 enable=0 in any state SHALL force IDLE on the next edge and clear cnt, good_run and locked; no meas_valid is issued, and the last result outputs are retained.
REQ-027 An edge coinciding with cnt saturation SHALL be treated as a timeout.

Reset
REQ-028 rst SHALL force IDLE and set every output, cnt, good_run and sig_q to 0, regardless of enable or sig_in.
REQ-029 rst during measurement SHALL discard the partial count; the first result after reset requires a full new rise-fall-rise sequence.

Configuration
REQ-030 Macro CLK_MON_STATS_EN defined: min_period and max_period SHALL track the extremes of period_cnt over all valid measurements since enable rose; min_period initialises to all-ones and max_period to 0.
REQ-031 Macro CLK_MON_STATS_EN absent: min_period and max_period SHALL be tied to 0 and their tracking logic SHALL be absent.

Structure
REQ-032 Package clk_mon_pkg SHALL hold the FSM state enum typedef and the default CNT_W and LOCK_CNT constants.
REQ-033 Edge detection SHALL be a sub-module clk_mon_edge (sig_in in; rise and fall out; one register).

Verification
REQ-034 sig_in toggling every 2 clk cycles, exp_half=2, tol=0 -> meas_valid every 4 cycles with high_cnt=2, low_cnt=2, period_cnt=4, err=0; locked=1 after the 4th meas_valid.
REQ-035 sig_in toggling every cycle, exp_half=2, tol=0 -> high_cnt=1, low_cnt=1, err=1 on every measurement, locked stays 0; the same stimulus with tol=1 -> err=0.
REQ-036 CNT_W=8, sig_in held at 1 after a rise -> ovf=1 after cnt reaches 255, FSM in WAIT_EDGE, no meas_valid, locked=0.
REQ-037 enable dropped during MEAS_HIGH after lock -> IDLE next cycle, locked=0, no meas_valid; high_cnt and low_cnt keep their prior values.
REQ-038 rst pulsed during MEAS_LOW -> all outputs 0 on the next cycle; resuming 2-cycle toggling yields the first meas_valid only after a full rise-fall-rise sequence.
REQ-039 With CLK_MON_STATS_EN, alternating half-periods of 2/2 then 3/3 -> min_period=4, max_period=6.
